// File: rtl/word_unpack_pkg.sv
// word_unpack_pkg: default geometry and filter-counter sizing shared by word_unpack.
package word_unpack_pkg;
  localparam int WIDTH_DEF    = 16;
  localparam int FILT_LEN_DEF = 4;
  function automatic int cnt_w(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction
endpackage

// File: rtl/word_unpack_bit.sv
// word_unpack_bit: one bit's optional glitch filter, edge pulses and sticky rise flag.
// Filter compiled in only when WORD_UNPACK_FILTER_EN is defined.
module word_unpack_bit
  import word_unpack_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic valid_i,
  input  logic clr_i,
  output logic bit_o,
  output logic rise_o,
  output logic fall_o,
  output logic sticky_o
);
  logic bit_q, bit_d, rise_q, rise_d, fall_q, fall_d, sticky_q, sticky_d;
  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt
    $error("word_unpack_bit: FILT_LEN out of range");
  end
`ifdef WORD_UNPACK_FILTER_EN
  localparam int CW = cnt_w(FILT_LEN);
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff, done;
  // The counter tracks the current disagreeing run; any agreeing sample restarts it.
  always_comb begin
    diff  = valid_i && (in_i != bit_q);
    done  = diff && (cnt_q == CW'(FILT_LEN - 1));
    cnt_d = !valid_i ? cnt_q : (diff && !done) ? cnt_q + 1'b1 : '0;
    bit_d = done ? ~bit_q : bit_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  always_comb bit_d = valid_i ? in_i : bit_q;
`endif
  always_comb begin
    rise_d   = ~bit_q & bit_d;
    fall_d   = bit_q & ~bit_d;
    sticky_d = rise_d | (sticky_q & ~clr_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      bit_q    <= bit_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end
  assign bit_o    = bit_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign sticky_o = sticky_q;
endmodule

// File: rtl/word_unpack.sv
// word_unpack: registers a status word into per-bit levels, edge pulses and sticky rise flags.
// Define WORD_UNPACK_FILTER_EN to add a FILT_LEN-sample glitch filter per bit.
module word_unpack
  import word_unpack_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] bits_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic [WIDTH-1:0] sticky_out
);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("word_unpack: WIDTH out of range");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    word_unpack_bit #(.FILT_LEN(FILT_LEN)) u_bit (
      .clk     (clk),
      .rst     (rst),
      .in_i    (word_in[i]),
      .valid_i (word_valid),
      .clr_i   (clr_mask[i]),
      .bit_o   (bits_out[i]),
      .rise_o  (rise_out[i]),
      .fall_o  (fall_out[i]),
      .sticky_o(sticky_out[i])
    );
  end
endmodule

// File: tb/tb_word_unpack.sv
// tb_word_unpack: directed and random stimulus checked by a queued reference model.
module tb_word_unpack;
  localparam int W = 16;
`ifdef WORD_UNPACK_FILTER_EN
  localparam int FL = 4;
`else
  localparam int FL = 1;
`endif
  typedef struct packed {
    logic [W-1:0] b, r, f, s;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, word_valid = 1'b0;
  logic [W-1:0] word_in = '0, clr_mask = '0;
  logic [W-1:0] bits_out, rise_out, fall_out, sticky_out;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] m_b = '0, m_r = '0, m_f = '0, m_s = '0;
  int run[W];

  word_unpack #(.WIDTH(W), .FILT_LEN(4)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .clr_mask(clr_mask), .bits_out(bits_out), .rise_out(rise_out),
    .fall_out(fall_out), .sticky_out(sticky_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bit changes once it has seen FL consecutive valid disagreeing samples.
  task automatic model(input logic [W-1:0] w, input logic v, input logic [W-1:0] c, input logic r);
    if (r) begin
      m_b = '0; m_r = '0; m_f = '0; m_s = '0;
      for (int k = 0; k < W; k++) run[k] = 0;
      return;
    end
    m_r = '0; m_f = '0;
    for (int k = 0; k < W; k++) begin
      if (v) begin
        if (w[k] == m_b[k]) run[k] = 0;
        else begin
          run[k]++;
          if (run[k] == FL) begin
            run[k] = 0;
            m_b[k] = w[k];
            if (w[k]) m_r[k] = 1'b1; else m_f[k] = 1'b1;
          end
        end
      end
      m_s[k] = m_r[k] | (m_s[k] & ~c[k]);
    end
  endtask

  task automatic step(input logic [W-1:0] w, input logic v, input logic [W-1:0] c, input logic r);
    @(negedge clk);
    rst = r; word_in = w; word_valid = v; clr_mask = c;
    model(w, v, c, r);
    q.push_back('{m_b, m_r, m_f, m_s});
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_bits", bits_out, '0);
    chk("async_rise", rise_out, '0);
    chk("async_fall", fall_out, '0);
    chk("async_sticky", sticky_out, '0);
    model('0, 1'b0, '0, 1'b1);
    step('0, 1'b0, '0, 1'b1);
    step('0, 1'b1, '0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bits_out", bits_out, e.b);
        chk("rise_out", rise_out, e.r);
        chk("fall_out", fall_out, e.f);
        chk("sticky_out", sticky_out, e.s);
      end
    end
  end

  initial begin : driver
    logic [W-1:0] w;
    logic [7:0] pat;
    for (int k = 0; k < W; k++) run[k] = 0;
    #3;
    chk("reset_bits", bits_out, '0);
    chk("reset_sticky", sticky_out, '0);
    step('0, 1'b0, '0, 1'b1);
    step('0, 1'b0, '0, 1'b0);
    // Whole-word capture and the following quiet cycles.
    for (int k = 0; k < FL; k++) step(16'h00A5, 1'b1, '0, 1'b0);
    for (int k = 0; k < 3; k++) step(16'h00A5, 1'b0, '0, 1'b0);
    for (int k = 0; k < FL + 1; k++) step('0, 1'b1, 16'hFFFF, 1'b0);
    // Held 0->1 on bit 3.
    for (int k = 0; k < 6; k++) step(16'h0008, 1'b1, '0, 1'b0);
    for (int k = 0; k < 6; k++) step(16'h0000, 1'b1, 16'h0008, 1'b0);
    // Glitch restart pattern on bit 3.
    pat = 8'b1111_0111;
    for (int k = 0; k < 8; k++) step(pat[k] ? 16'h0008 : 16'h0000, 1'b1, '0, 1'b0);
    for (int k = 0; k < FL + 1; k++) step('0, 1'b1, '0, 1'b0);
    // Valid toggling with a constant disagreeing bit.
    for (int k = 0; k < 9; k++) step(16'h0008, (k % 2) == 0, '0, 1'b0);
    for (int k = 0; k < FL + 1; k++) step('0, 1'b1, '0, 1'b0);
    // Sticky: clear coinciding with a new rise keeps it set; the next clear drops it.
    for (int k = 0; k < FL; k++) step(16'h0001, 1'b1, '0, 1'b0);
    for (int k = 0; k < FL; k++) step(16'h0000, 1'b1, '0, 1'b0);
    for (int k = 0; k < FL; k++) step(16'h0001, 1'b1, 16'h0001, 1'b0);
    step(16'h0001, 1'b0, 16'h0001, 1'b0);
    step(16'h0001, 1'b0, '0, 1'b0);
    // Reset in the middle of a partial run, then a full fresh run.
    step(16'h0008, 1'b1, '0, 1'b0);
    step(16'h0008, 1'b1, '0, 1'b0);
    async_reset();
    for (int k = 0; k < FL + 2; k++) step(16'h0008, 1'b1, '0, 1'b0);
    // Random phase: sparse bit flips so filtered runs complete and break.
    w = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) w = w ^ W'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      step(w, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 65535)) : '0,
           1'b0);
      if (n == 200) async_reset();
    end
    step(w, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
